datapath: RTL and testbench
===========================

Name: datapath

Overview:
- Single-bus 32-bit CPU datapath: general registers, PC, IR, MAR, MDR, Y, 64-bit Z, HI and LO around one shared 32-bit bus.
- ALU supports PC increment, add and signed multiply.
- Driven cycle-by-cycle by an external control unit (or bench) through one-hot "out" bus-select strobes and "in" register-load strobes.
- Used to exercise instruction fetch plus the MUL sequence: Y <- Ra; Z <- Y*Rb; LO <- Zlow; HI <- Zhigh.

Parameters:
- WIDTH, 32, data/bus width; Z is 2*WIDTH.

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- MDatain  in  32  memory read data, captured into MDR when Read=1.
- Read  in  1  MDR input mux select: 1 = MDatain, 0 = bus.
- PCout, Zlowout, Zhighout, MDRout, LOout, HIout, Cout, InPortout  in  1 each  bus drive selects.
- R2out, R3out, R4out, R5out, R7out  in  1 each  general-register bus drive selects.
- PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin  in  1 each  register load enables.
- R1in, R2in, R3in, R4in, R5in  in  1 each  general-register load enables.
- IncPC  in  1  ALU op: Z <- bus + 1.
- MUL  in  1  ALU op: Z <- signed Y * bus.

Behaviour:
- Reset: already decided as one clock, reset synchronous and active-high. On a rising edge with clr=1, PC, IR, MAR, MDR, Y, Z, HI, LO and R1..R7 all clear to 0; clr overrides every load enable.
- Registers: rising-edge clocked. A register with its "in" strobe high at the edge loads the bus value; otherwise it holds. Control strobes must be stable across the rising edge.
- MDR: on MDRin=1 it loads MDatain if Read=1, else the bus.
- Bus: combinational one-hot mux.
  - Fixed priority when several selects are high: PCout > MDRout > Zlowout > Zhighout > LOout > HIout > R2out > R3out > R4out > R5out > R7out > Cout > InPortout.
  - No select high -> bus = 0.
- Bus sources:
  - Zlowout drives Z[31:0]; Zhighout drives Z[63:32].
  - Cout drives IR[18:0] sign-extended to 32 bits.
  - InPortout drives 0; the in-port unit is outside this block.
- R6 and R7 exist internally but have no load strobe, so they stay 0. R7out therefore drives 0.
- ALU: combinational from Y and bus; Z loads on Zin.
  - Priority MUL > IncPC > default add.
  - MUL: Z = signed(Y) * signed(bus), full 64-bit two's-complement product.
  - IncPC: Z = {32'h0, bus + 1}, wrapping at 2^32.
  - Default (neither op): Z = {32'h0, Y + bus}, wrapping, carry discarded.
- Latency: a register-to-register transfer takes 1 cycle. MUL takes 2 cycles to reach Z (Yin, then Zin), 1 more for LO and 1 more for HI.
- Simultaneous events:
  - A register may drive the bus and load in the same cycle; it loads the value present before the edge.
  - Multiple load enables may be high together; all of them load the same bus value.
- Reset mid-sequence: all state clears. The next instruction sequence must restart from fetch.

Test Plan:
- Reset: clr=1 for one edge after arbitrary loads -> PC=IR=MAR=MDR=Y=Z=HI=LO=R1..R5=0.
- Register load: MDatain=0xFFFFFFFC, Read=1+MDRin; then MDRout+R4in -> R4=0xFFFFFFFC. Repeat with 0xFFFFFFFB into R5 and 0 into R1 -> R5=0xFFFFFFFB, R1=0.
- Fetch, PC=0: PCout+MARin+IncPC+Zin -> MAR=0, Z=1. Then Zlowout+PCin with Read+MDRin, MDatain=0x28918000 -> PC=1, MDR=0x28918000. Then MDRout+IRin -> IR=0x28918000.
- MUL negatives: R4out+Yin; R5out+MUL+Zin; Zlowout+LOin; Zhighout+HIin -> Y=0xFFFFFFFC, Z=0x0000000000000014, LO=0x14, HI=0.
- MUL mixed sign/overflow: R4=0x80000000, R5=2 -> HI=0xFFFFFFFF, LO=0x00000000. R4=0xFFFFFFFF, R5=1 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF.
- Bus edge cases: no out select -> bus=0 (Yin loads 0). PCout and MDRout both high -> PC value wins. IR=0x00040000, Cout+Yin -> Y=0xFFFC0000. IncPC with PC=0xFFFFFFFF -> Z low=0.

Source files
------------

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: PC, IR, MAR, MDR, Y, 64-bit Z, HI, LO and
// R1..R7 share one bus that is driven by a fixed-priority source mux. A small
// ALU (increment, add, signed multiply) sits between Y/bus and Z.
module datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] MDatain,
  input  logic             Read,
  input  logic             PCout,
  input  logic             Zlowout,
  input  logic             Zhighout,
  input  logic             MDRout,
  input  logic             LOout,
  input  logic             HIout,
  input  logic             Cout,
  input  logic             InPortout,
  input  logic             R2out,
  input  logic             R3out,
  input  logic             R4out,
  input  logic             R5out,
  input  logic             R7out,
  input  logic             PCin,
  input  logic             IRin,
  input  logic             MARin,
  input  logic             MDRin,
  input  logic             Yin,
  input  logic             Zin,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             R1in,
  input  logic             R2in,
  input  logic             R3in,
  input  logic             R4in,
  input  logic             R5in,
  input  logic             IncPC,
  input  logic             MUL,
  output logic [WIDTH-1:0] mar_o,
  output logic [WIDTH-1:0] ir_o
);

  logic [WIDTH-1:0]   pc_q,  pc_d;
  logic [WIDTH-1:0]   ir_q,  ir_d;
  logic [WIDTH-1:0]   mar_q, mar_d;
  logic [WIDTH-1:0]   mdr_q, mdr_d;
  logic [WIDTH-1:0]   y_q,   y_d;
  logic [2*WIDTH-1:0] z_q,   z_d;
  logic [WIDTH-1:0]   hi_q,  hi_d;
  logic [WIDTH-1:0]   lo_q,  lo_d;
  // R6 and R7 have no load strobe, so they only ever hold their reset value.
  logic [WIDTH-1:0]   gpr_q [1:7];
  logic [WIDTH-1:0]   gpr_d [1:7];

  logic [WIDTH-1:0]          busData;
  logic [WIDTH-1:0]          cSignExt;
  logic signed [2*WIDTH-1:0] mulA;
  logic signed [2*WIDTH-1:0] mulB;
  logic signed [2*WIDTH-1:0] mulProduct;
  logic [2*WIDTH-1:0]        aluResult;

  assign cSignExt = {{(WIDTH-19){ir_q[18]}}, ir_q[18:0]};

  // Shared bus: the highest-priority asserted select wins, nothing selected gives 0.
  always_comb begin
    busData = '0;
    if (PCout)          busData = pc_q;
    else if (MDRout)    busData = mdr_q;
    else if (Zlowout)   busData = z_q[WIDTH-1:0];
    else if (Zhighout)  busData = z_q[2*WIDTH-1:WIDTH];
    else if (LOout)     busData = lo_q;
    else if (HIout)     busData = hi_q;
    else if (R2out)     busData = gpr_q[2];
    else if (R3out)     busData = gpr_q[3];
    else if (R4out)     busData = gpr_q[4];
    else if (R5out)     busData = gpr_q[5];
    else if (R7out)     busData = gpr_q[7];
    else if (Cout)      busData = cSignExt;
    else if (InPortout) busData = '0;
  end

  // ALU: both operands sign-extended to 2*WIDTH so the truncated product is the exact signed result.
  always_comb begin
    mulA       = {{WIDTH{y_q[WIDTH-1]}}, y_q};
    mulB       = {{WIDTH{busData[WIDTH-1]}}, busData};
    mulProduct = mulA * mulB;
    if (MUL)        aluResult = mulProduct;
    else if (IncPC) aluResult = {{WIDTH{1'b0}}, busData + WIDTH'(1)};
    else            aluResult = {{WIDTH{1'b0}}, y_q + busData};
  end

  // Next-state: every register holds unless its load strobe is high.
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    mar_d = mar_q;
    mdr_d = mdr_q;
    y_d   = y_q;
    z_d   = z_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    gpr_d = gpr_q;
    if (PCin)  pc_d  = busData;
    if (IRin)  ir_d  = busData;
    if (MARin) mar_d = busData;
    if (MDRin) mdr_d = Read ? MDatain : busData;
    if (Yin)   y_d   = busData;
    if (Zin)   z_d   = aluResult;
    if (HIin)  hi_d  = busData;
    if (LOin)  lo_d  = busData;
    if (R1in)  gpr_d[1] = busData;
    if (R2in)  gpr_d[2] = busData;
    if (R3in)  gpr_d[3] = busData;
    if (R4in)  gpr_d[4] = busData;
    if (R5in)  gpr_d[5] = busData;
  end

  // State register with synchronous clear that overrides every load.
  always_ff @(posedge clk) begin
    if (clr) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      for (int i = 1; i <= 7; i++) gpr_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      z_q   <= z_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      for (int i = 1; i <= 7; i++) gpr_q[i] <= gpr_d[i];
    end
  end

  assign mar_o = mar_q;
  assign ir_o  = ir_q;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for the datapath: each step drives strobes, queues the register
// values it should produce, and after the clock edge pops and compares them.
module tb_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] MDatain;
  logic Read, PCout, Zlowout, Zhighout, MDRout, LOout, HIout, Cout, InPortout;
  logic R2out, R3out, R4out, R5out, R7out;
  logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
  logic R1in, R2in, R3in, R4in, R5in, IncPC, MUL;
  logic [31:0] marObs, irObs;

  int compareCount = 0;
  int failCount    = 0;

  typedef enum int {
    SEL_PC, SEL_IR, SEL_MAR, SEL_MDR, SEL_Y, SEL_Z, SEL_HI, SEL_LO,
    SEL_R1, SEL_R2, SEL_R3, SEL_R4, SEL_R5
  } sel_e;

  typedef struct {
    string       tag;
    sel_e        sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sbQ[$];

  datapath #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr), .MDatain(MDatain), .Read(Read),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .LOout(LOout), .HIout(HIout), .Cout(Cout), .InPortout(InPortout),
    .R2out(R2out), .R3out(R3out), .R4out(R4out), .R5out(R5out), .R7out(R7out),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
    .Zin(Zin), .HIin(HIin), .LOin(LOin),
    .R1in(R1in), .R2in(R2in), .R3in(R3in), .R4in(R4in), .R5in(R5in),
    .IncPC(IncPC), .MUL(MUL), .mar_o(marObs), .ir_o(irObs)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  function automatic logic [63:0] observe(input sel_e s);
    case (s)
      SEL_PC:  return {32'h0, dut.pc_q};
      SEL_IR:  return {32'h0, irObs};
      SEL_MAR: return {32'h0, marObs};
      SEL_MDR: return {32'h0, dut.mdr_q};
      SEL_Y:   return {32'h0, dut.y_q};
      SEL_Z:   return dut.z_q;
      SEL_HI:  return {32'h0, dut.hi_q};
      SEL_LO:  return {32'h0, dut.lo_q};
      SEL_R1:  return {32'h0, dut.gpr_q[1]};
      SEL_R2:  return {32'h0, dut.gpr_q[2]};
      SEL_R3:  return {32'h0, dut.gpr_q[3]};
      SEL_R4:  return {32'h0, dut.gpr_q[4]};
      default: return {32'h0, dut.gpr_q[5]};
    endcase
  endfunction

  task automatic pushExpect(input string tag, input sel_e sel, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sbQ.push_back(e);
  endtask

  task automatic clearStrobes();
    Read = 0; PCout = 0; Zlowout = 0; Zhighout = 0; MDRout = 0; LOout = 0;
    HIout = 0; Cout = 0; InPortout = 0; R2out = 0; R3out = 0; R4out = 0;
    R5out = 0; R7out = 0; PCin = 0; IRin = 0; MARin = 0; MDRin = 0; Yin = 0;
    Zin = 0; HIin = 0; LOin = 0; R1in = 0; R2in = 0; R3in = 0; R4in = 0;
    R5in = 0; IncPC = 0; MUL = 0; clr = 0;
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [63:0] obs;
    while (sbQ.size() > 0) begin
      e   = sbQ.pop_front();
      obs = observe(e.sel);
      compareCount++;
      assert (obs === e.exp) else begin
        failCount++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // One clock: strobes already set, sample 1 unit after the edge, then idle the strobes.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    checkOutput();
    clearStrobes();
  endtask

  task automatic setRin(input int idx);
    case (idx)
      1: R1in = 1;
      2: R2in = 1;
      3: R3in = 1;
      4: R4in = 1;
      default: R5in = 1;
    endcase
  endtask

  task automatic setRout(input int idx);
    case (idx)
      2: R2out = 1;
      3: R3out = 1;
      4: R4out = 1;
      5: R5out = 1;
      default: R7out = 1;
    endcase
  endtask

  task automatic loadViaMdr(input logic [31:0] v);
    MDatain = v; Read = 1; MDRin = 1;
    pushExpect("mdr_read", SEL_MDR, {32'h0, v});
    applyStimulus();
  endtask

  task automatic loadGpr(input int idx, input logic [31:0] v);
    loadViaMdr(v);
    MDRout = 1;
    setRin(idx);
    pushExpect($sformatf("r%0d_load", idx), sel_e'(int'(SEL_R1) + idx - 1), {32'h0, v});
    applyStimulus();
  endtask

  task automatic mulSeq(input int ra, input int rb, input logic [31:0] yExp,
                        input logic [63:0] zExp);
    setRout(ra); Yin = 1;
    pushExpect("mul_y", SEL_Y, {32'h0, yExp});
    applyStimulus();
    setRout(rb); MUL = 1; Zin = 1;
    pushExpect("mul_z", SEL_Z, zExp);
    applyStimulus();
    Zlowout = 1; LOin = 1;
    pushExpect("mul_lo", SEL_LO, {32'h0, zExp[31:0]});
    applyStimulus();
    Zhighout = 1; HIin = 1;
    pushExpect("mul_hi", SEL_HI, {32'h0, zExp[63:32]});
    applyStimulus();
  endtask

  initial begin
    clearStrobes();
    MDatain = 32'h0;

    // Bring the design to a known state.
    clr = 1;
    pushExpect("init_pc", SEL_PC, 64'h0);
    applyStimulus();

    // Arbitrary loads, including default add into Z, then a clear that must win over loads.
    loadViaMdr(32'hDEADBEEF);
    MDRout = 1; R1in = 1; R2in = 1; R3in = 1; R4in = 1; R5in = 1; PCin = 1;
    IRin = 1; MARin = 1; Yin = 1; Zin = 1; HIin = 1; LOin = 1;
    pushExpect("multi_load_r3", SEL_R3, 64'hDEADBEEF);
    pushExpect("multi_load_hi", SEL_HI, 64'hDEADBEEF);
    pushExpect("add_y0_plus_bus", SEL_Z, 64'hDEADBEEF);
    applyStimulus();
    clr = 1; MDRout = 1; PCin = 1; R1in = 1; Yin = 1; Zin = 1; MDRin = 1;
    pushExpect("rst_pc", SEL_PC, 64'h0);   pushExpect("rst_ir", SEL_IR, 64'h0);
    pushExpect("rst_mar", SEL_MAR, 64'h0); pushExpect("rst_mdr", SEL_MDR, 64'h0);
    pushExpect("rst_y", SEL_Y, 64'h0);     pushExpect("rst_z", SEL_Z, 64'h0);
    pushExpect("rst_hi", SEL_HI, 64'h0);   pushExpect("rst_lo", SEL_LO, 64'h0);
    pushExpect("rst_r1", SEL_R1, 64'h0);   pushExpect("rst_r2", SEL_R2, 64'h0);
    pushExpect("rst_r3", SEL_R3, 64'h0);   pushExpect("rst_r4", SEL_R4, 64'h0);
    pushExpect("rst_r5", SEL_R5, 64'h0);
    applyStimulus();

    // Register loads through MDR.
    loadGpr(4, 32'hFFFFFFFC);
    loadGpr(5, 32'hFFFFFFFB);
    loadGpr(1, 32'h00000000);

    // Instruction fetch from PC=0.
    PCout = 1; MARin = 1; IncPC = 1; Zin = 1;
    pushExpect("fetch_mar", SEL_MAR, 64'h0);
    pushExpect("fetch_z", SEL_Z, 64'h1);
    applyStimulus();
    Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; MDatain = 32'h28918000;
    pushExpect("fetch_pc", SEL_PC, 64'h1);
    pushExpect("fetch_mdr", SEL_MDR, 64'h28918000);
    applyStimulus();
    MDRout = 1; IRin = 1;
    pushExpect("fetch_ir", SEL_IR, 64'h28918000);
    applyStimulus();

    // Signed multiply: negative*negative, overflow into HI, and -1*1.
    mulSeq(4, 5, 32'hFFFFFFFC, 64'h0000000000000014);
    loadGpr(4, 32'h80000000);
    loadGpr(5, 32'h00000002);
    mulSeq(4, 5, 32'h80000000, 64'hFFFFFFFF00000000);
    loadGpr(4, 32'hFFFFFFFF);
    loadGpr(5, 32'h00000001);
    mulSeq(4, 5, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);

    // Bus with no source selected reads as zero.
    Yin = 1;
    pushExpect("bus_idle_y", SEL_Y, 64'h0);
    applyStimulus();

    // PC beats MDR when both drive.
    loadViaMdr(32'hFFFFFFFF);
    MDRout = 1; PCin = 1;
    pushExpect("pc_load", SEL_PC, 64'hFFFFFFFF);
    applyStimulus();
    loadViaMdr(32'h12345678);
    PCout = 1; MDRout = 1; Yin = 1;
    pushExpect("prio_pc_over_mdr", SEL_Y, 64'hFFFFFFFF);
    applyStimulus();

    // Increment wraps at 2^32 and leaves the high half clear.
    PCout = 1; IncPC = 1; Zin = 1;
    pushExpect("incpc_wrap", SEL_Z, 64'h0);
    applyStimulus();

    // Sign-extended constant field of IR.
    loadViaMdr(32'h00040000);
    MDRout = 1; IRin = 1;
    pushExpect("ir_const", SEL_IR, 64'h00040000);
    applyStimulus();
    Cout = 1; Yin = 1;
    pushExpect("cout_sext", SEL_Y, 64'hFFFC0000);
    applyStimulus();

    // Default add discards the carry.
    R4out = 1; Zin = 1;
    pushExpect("add_wrap", SEL_Z, 64'h00000000FFFBFFFF);
    applyStimulus();

    // R7 has no load path so it drives zero.
    R7out = 1; Yin = 1;
    pushExpect("r7_zero", SEL_Y, 64'h0);
    applyStimulus();

    // Mid-sequence clear, then fetch restarts from address 0.
    clr = 1;
    pushExpect("midrst_pc", SEL_PC, 64'h0);
    pushExpect("midrst_ir", SEL_IR, 64'h0);
    pushExpect("midrst_r4", SEL_R4, 64'h0);
    applyStimulus();
    PCout = 1; MARin = 1; IncPC = 1; Zin = 1;
    pushExpect("refetch_mar", SEL_MAR, 64'h0);
    pushExpect("refetch_z", SEL_Z, 64'h1);
    applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
